spi_mem_cmd_parser: RTL
=======================

Name: spi_mem_cmd_parser

Overview:
- Byte-stream command decoder between the SPI slave's RX/TX FIFO ports and a single-port synchronous BRAM.
- Replaces the implicit 0xFF/0xFE auto-increment protocol with addressed, length-framed WRITE and READ packets.
- Consumes RX bytes, drives the BRAM port, and produces read data into the TX FIFO. Frames are aborted on chip-select release.

Parameters:
- ADDR_WIDTH, 8, BRAM address width (1..16); address is sent as 1 byte if <=8, else 2 bytes MSB first.
- OP_WRITE, 8'h01, write opcode.
- OP_READ, 8'h02, read opcode.
- OP_NOP, 8'h00, ignored opcode.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- frame_abort  in  1  single-cycle pulse on spi_cs_n rising edge (synchronous to clk).
- rx_data  in  8  byte from RX FIFO.
- rx_valid  in  1  RX byte available.
- rx_ready  out  1  byte consumed when rx_valid&&rx_ready.
- tx_data  out  8  read byte to TX FIFO.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  TX FIFO accepts.
- mem_addr  out  ADDR_WIDTH  BRAM address.
- mem_wdata  out  8  BRAM write data.
- mem_we  out  1  BRAM write strobe.
- mem_re  out  1  BRAM read strobe; mem_rdata valid exactly 1 cycle later.
- mem_rdata  in  8  BRAM read data.
- busy  out  1  high in any state other than IDLE.
- err_count  out  8  saturating count of unknown opcodes.

Behaviour:
- Reset values (async, rst high): state=IDLE; rx_ready=0; tx_valid=0; tx_data=0; mem_we=0; mem_re=0; mem_addr=0; mem_wdata=0; busy=0; err_count=0.
- Outside reset, rx_ready=1 in every state. The block never back-pressures RX.
- Packet format: opcode, address byte(s), LEN byte, then payload. LEN=0 means 256 bytes. The internal byte counter is 9 bits.
- FSM states: IDLE, ADDR_HI, ADDR_LO, LEN, WR_DATA, RD_ISSUE, RD_WAIT, RD_PUSH.
- IDLE:
  - OP_WRITE or OP_READ: go to ADDR_HI if ADDR_WIDTH>8, else ADDR_LO; latch the opcode.
  - OP_NOP: stay in IDLE.
  - Any other byte: err_count+1, saturating at 255; stay in IDLE.
- ADDR_HI captures addr[ADDR_WIDTH-1:8]. ADDR_LO captures addr[7:0]. Unused high bits are discarded.
- LEN: load the count. Write goes to WR_DATA. Read goes to RD_ISSUE.
- WR_DATA, on each accepted byte:
  - mem_we=1 for exactly that cycle, with mem_addr=addr and mem_wdata=byte.
  - addr+1 (wraps modulo 2^ADDR_WIDTH); count-1.
  - After the last byte, go to IDLE.
  - Write latency: strobe one cycle after byte acceptance (registered outputs).
- RD_ISSUE: mem_re=1 with mem_addr=addr for one cycle, then RD_WAIT.
- RD_WAIT: capture mem_rdata into tx_data; set tx_valid=1; go to RD_PUSH.
- RD_PUSH: hold tx_valid and tx_data stable until tx_ready. On the handshake cycle:
  - tx_valid=0; addr+1 (wraps); count-1.
  - If count reaches 0, go to IDLE, else RD_ISSUE.
  - Throughput: at most one byte per 3 cycles.
- RX bytes accepted during RD_* states are host dummy bytes. They are discarded and do not affect state or err_count.
- frame_abort in any state: next state is IDLE; tx_valid=0; mem_we/mem_re=0. The partially transferred packet is lost, but bytes already written remain.
  - Abort in the same cycle as an accepted RX byte: abort wins and the byte is dropped.
  - Abort is the only permitted case of tx_valid falling without a handshake.
- frame_abort in IDLE has no effect.
- Reset mid-packet: return to reset values immediately. BRAM contents are untouched.
- mem_we and mem_re are never high in the same cycle.

Decomposition:
- Shared package spi_mem_pkg: opcode constants (OP_NOP, OP_WRITE, OP_READ), FSM state encoding, LEN_ZERO_MEANS_256 note/constant.
- No sub-module needed. The BRAM stays external so the top-level instantiates the inferred memory.

Test Plan:
- Write then read back: send 01 10 03 AA BB CC, then 02 10 03 + 3 dummies. Expect mem_we at addr 0x10/0x11/0x12 with AA/BB/CC; TX yields AA BB CC; busy returns 0.
- Wrap and LEN=0: send 01 FE 00 + 256 bytes (0..255). Expect addresses FE, FF, 00 … FD; then reading 02 FE 02 returns 00 01.
- TX backpressure: read 3 bytes with tx_ready held low 10 cycles per byte. Expect tx_valid/tx_data stable while stalled, exactly 3 handshakes, and no mem_re issued while in RD_PUSH.
- Abort mid-write: 01 20 04 11 22, then frame_abort. Expect only 0x20/0x21 written; state IDLE; next byte 02 is parsed as an opcode.
- Unknown opcodes: send 0x55 ×300 plus 00. Expect err_count saturates at 255; no mem strobes; NOP changes nothing.
- Reset during RD_PUSH: assert rst while tx_valid=1. Expect tx_valid, busy, and rx_ready go to 0 asynchronously; after release, IDLE accepts a new packet normally.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared constants and FSM encoding for the SPI memory command parser.
// Opcodes and the LEN byte convention used by host packets.
package spi_mem_pkg;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

    // A LEN byte of zero frames a full 256-byte payload.
    localparam int LEN_ZERO_MEANS_256 = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_LEN,
        S_WR_DATA,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_PUSH
    } state_t;

    function automatic logic [8:0] len_to_count(input logic [7:0] len);
        return (len == 8'h00) ? 9'(LEN_ZERO_MEANS_256) : {1'b0, len};
    endfunction

endpackage

// File: rtl/spi_mem_cmd_parser.sv
// Decodes addressed, length-framed WRITE/READ packets from the SPI RX byte
// stream into BRAM strobes, returning read data through the TX FIFO port.
module spi_mem_cmd_parser #(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] OP_WRITE   = spi_mem_pkg::OP_WRITE,
    parameter logic [7:0] OP_READ    = spi_mem_pkg::OP_READ,
    parameter logic [7:0] OP_NOP     = spi_mem_pkg::OP_NOP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_abort,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [7:0]            mem_rdata,
    output logic                  busy,
    output logic [7:0]            err_count
);
    import spi_mem_pkg::*;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] addr, addr_n, maddr_n;
    logic [8:0]            count, count_n;
    logic                  op_rd, op_rd_n;
    logic [7:0]            err_n, wdata_n, txd_n;
    logic                  we_n, re_n, txv_n;
    logic                  take;

    assign take = rx_valid && rx_ready;
    assign busy = (state != S_IDLE);

    always_comb begin
        state_n = state;
        addr_n  = addr;
        count_n = count;
        op_rd_n = op_rd;
        err_n   = err_count;
        we_n    = 1'b0;
        re_n    = 1'b0;
        maddr_n = mem_addr;
        wdata_n = mem_wdata;
        txd_n   = tx_data;
        txv_n   = tx_valid;
        unique case (state)
            S_IDLE: begin
                if (take) begin
                    if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                        op_rd_n = (rx_data == OP_READ);
                        state_n = (ADDR_WIDTH > 8) ? S_ADDR_HI : S_ADDR_LO;
                    end else if (rx_data != OP_NOP && err_count != 8'hFF) begin
                        err_n = err_count + 8'd1;
                    end
                end
            end
            S_ADDR_HI: begin
                if (take) begin
                    addr_n  = ADDR_WIDTH'({rx_data, 8'h00})
                            | (addr & ADDR_WIDTH'(16'h00FF));
                    state_n = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                if (take) begin
                    addr_n  = (addr & ~ADDR_WIDTH'(16'h00FF))
                            | ADDR_WIDTH'(rx_data);
                    state_n = S_LEN;
                end
            end
            S_LEN: begin
                if (take) begin
                    count_n = len_to_count(rx_data);
                    if (op_rd) begin
                        state_n = S_RD_ISSUE;
                        re_n    = 1'b1;
                        maddr_n = addr;
                    end else begin
                        state_n = S_WR_DATA;
                    end
                end
            end
            S_WR_DATA: begin
                if (take) begin
                    we_n    = 1'b1;
                    maddr_n = addr;
                    wdata_n = rx_data;
                    addr_n  = addr + 1'b1;
                    count_n = count - 9'd1;
                    if (count == 9'd1) state_n = S_IDLE;
                end
            end
            S_RD_ISSUE: state_n = S_RD_WAIT;
            S_RD_WAIT: begin
                txd_n   = mem_rdata;
                txv_n   = 1'b1;
                state_n = S_RD_PUSH;
            end
            S_RD_PUSH: begin
                // Strobe for the next byte is registered on the handshake edge
                // so it is already high in the RD_ISSUE cycle.
                if (tx_ready) begin
                    txv_n   = 1'b0;
                    addr_n  = addr + 1'b1;
                    count_n = count - 9'd1;
                    if (count == 9'd1) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_RD_ISSUE;
                        re_n    = 1'b1;
                        maddr_n = addr + 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (frame_abort) begin
            state_n = S_IDLE;
            err_n   = err_count;
            txv_n   = 1'b0;
            we_n    = 1'b0;
            re_n    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            addr      <= '0;
            count     <= '0;
            op_rd     <= 1'b0;
            err_count <= '0;
            rx_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            count     <= count_n;
            op_rd     <= op_rd_n;
            err_count <= err_n;
            rx_ready  <= 1'b1;
            mem_we    <= we_n;
            mem_re    <= re_n;
            mem_addr  <= maddr_n;
            mem_wdata <= wdata_n;
            tx_data   <= txd_n;
            tx_valid  <= txv_n;
        end
    end

endmodule
